// File: rtl/rambam_encoder.sv
// rambam_encoder: byte-to-codeword encoder.
// Each accepted plaintext byte is joined with D bits of LFSR state, multiplied by
// a GF(2) matrix and queued in a 2-entry output FIFO whose head drives out_data.
module rambam_encoder #(
    parameter int              D          = 4,
    // Identity of size (8+D): one set bit followed by (8+D) clear bits, repeated,
    // puts a 1 at every diagonal position of the row-major flattened matrix.
    parameter bit [0:7+D][0:7+D] ENC_MATRIX = {{(7+D){{1'b1, {(8+D){1'b0}}}}}, 1'b1},
    parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    input  logic          seed_valid,
    input  logic [15:0]   seed_data,
    output logic          out_valid,
    output logic [0:7+D]  out_data,
    input  logic          out_ready,
    output logic [15:0]   enc_count
);

    localparam int W = 8 + D;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // One LFSR step: shift left, feedback from taps 15, 13, 12, 10.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Pre-vector: byte MSB first at index 0, then r[0..D-1] = s[0..D-1].
    // D is expected to be at most 16 so every random bit comes from the state.
    function automatic logic [0:W-1] pre_vector(input logic [7:0] b, input logic [15:0] s);
        logic [0:W-1] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            v[i] = b[7-i];
        end
        for (int j = 0; j < D; j++) begin
            v[8+j] = s[j];
        end
        return v;
    endfunction

    // Row vector times matrix over GF(2): word[k] = XOR_j (v[j] & M[j][k]).
    function automatic logic [0:W-1] gf2_encode(input logic [0:W-1] v);
        logic [0:W-1] w;
        w = '0;
        for (int k = 0; k < W; k++) begin
            for (int j = 0; j < W; j++) begin
                w[k] = w[k] ^ (v[j] & ENC_MATRIX[j][k]);
            end
        end
        return w;
    endfunction

    occ_t         occ, occ_next;
    logic [15:0]  lfsr_s;
    logic [0:W-1] word_p0;
    logic [0:W-1] tail_p1;
    logic         push, pop;
    logic         load_head, head_from_tail, load_tail;

    // ---- stage p0: combinational encode of the offered byte ----
    assign word_p0 = gf2_encode(pre_vector(in_data, lfsr_s));

    // Handshakes derive from registered occupancy; reset blocks both sides.
    assign in_ready  = !rst && (occ != OCC_FULL);
    assign out_valid = !rst && (occ != OCC_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= OCC_EMPTY;
        end else begin
            occ <= occ_next;
        end
    end

    // Next occupancy plus head/tail load controls for the push/pop combination.
    always_comb begin
        occ_next       = occ;
        load_head      = 1'b0;
        head_from_tail = 1'b0;
        load_tail      = 1'b0;
        case (occ)
            OCC_EMPTY: begin
                if (push) begin
                    occ_next  = OCC_ONE;
                    load_head = 1'b1;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    // Head replaced in place: no bubble between words.
                    load_head = 1'b1;
                end else if (push) begin
                    occ_next  = OCC_FULL;
                    load_tail = 1'b1;
                end else if (pop) begin
                    occ_next = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    occ_next       = OCC_ONE;
                    load_head      = 1'b1;
                    head_from_tail = 1'b1;
                end
            end
            default: begin
                occ_next = OCC_EMPTY;
            end
        endcase
    end

    // ---- stage p1: FIFO head register (drives out_data, holds when idle) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else if (load_head) begin
            out_data <= head_from_tail ? tail_p1 : word_p0;
        end
    end

    // Second FIFO entry; only meaningful while occupancy is full.
    always_ff @(posedge clk) begin
        if (load_tail) begin
            tail_p1 <= word_p0;
        end
    end

    // LFSR: reseed wins over the per-accept step; a zero seed maps to LFSR_SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_s <= LFSR_SEED;
        end else if (seed_valid) begin
            lfsr_s <= (seed_data == 16'h0000) ? LFSR_SEED : seed_data;
        end else if (push) begin
            lfsr_s <= lfsr_step(lfsr_s);
        end
    end

    // Accepted-byte counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_count <= 16'h0000;
        end else if (push) begin
            enc_count <= enc_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_rambam_encoder.sv
// Directed self-checking bench for rambam_encoder (D=4, identity matrix).
`timescale 1ns/1ps
module tb_rambam_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        seed_valid;
    logic [15:0] seed_data;
    logic        out_valid;
    logic [0:11] out_data;
    logic        out_ready;
    logic [15:0] enc_count;

    int tests_run;
    int tests_failed;
    logic [15:0] ms;   // bench copy of the LFSR state

    rambam_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .seed_valid (seed_valid),
        .seed_data  (seed_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .enc_count  (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Identity-matrix codeword: byte MSB first, then r0..r3 = s[0..3].
    function automatic logic [0:11] wd(input logic [7:0] b, input logic [15:0] s);
        return {b, s[0], s[1], s[2], s[3]};
    endfunction

    function automatic logic [15:0] nx(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
        seed_valid = 1'b0; seed_data = 16'h0000;
        tick(); tick();
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_in_ready_during_rst: got %b expected 0", in_ready);
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tests_run++;
        if ({out_valid, out_data, enc_count, in_ready} !== {1'b0, 12'h000, 16'h0000, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_state: got vld=%b data=%h cnt=%h rdy=%b expected vld=0 data=000 cnt=0000 rdy=1",
                     out_valid, out_data, enc_count, in_ready);
        end
    endtask

    task automatic test_basic();
        seed_valid = 1'b1; seed_data = 16'h0001;
        tick();
        seed_valid = 1'b0;
        ms = 16'h0001;
        in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, 12'b1010_0101_1000}) begin
            tests_failed++; $display("FAIL basic_first: got vld=%b data=%b expected vld=1 data=101001011000", out_valid, out_data);
        end
        tick();
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, 12'b1010_0101_0100}) begin
            tests_failed++; $display("FAIL basic_second: got vld=%b data=%b expected vld=1 data=101001010100", out_valid, out_data);
        end
        ms = 16'h0004;
        in_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({out_valid, out_data, enc_count} !== {1'b0, 12'b1010_0101_0100, 16'd2}) begin
            tests_failed++;
            $display("FAIL basic_empty_hold: got vld=%b data=%b cnt=%0d expected vld=0 data=101001010100 cnt=2",
                     out_valid, out_data, enc_count);
        end
    endtask

    task automatic test_full();
        logic [7:0]  bytes [4];
        int          acc;
        logic [0:11] w0, w1;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        w0 = wd(8'h11, ms); ms = nx(ms);
        w1 = wd(8'h22, ms); ms = nx(ms);
        acc = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_data = bytes[acc];
            if (in_ready === 1'b1) acc++;
            tick();
        end
        tests_run++;
        if (acc != 2 || in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL full_accepts: got accepts=%0d rdy=%b expected accepts=2 rdy=0", acc, in_ready);
        end
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, w0}) begin
            tests_failed++; $display("FAIL full_stall_head: got vld=%b data=%h expected vld=1 data=%h", out_valid, out_data, w0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++; $display("FAIL full_no_comb_ready: got rdy=%b expected 0", in_ready);
        end
        tick();
        tests_run++;
        if ({out_valid, out_data, in_ready} !== {1'b1, w1, 1'b1}) begin
            tests_failed++;
            $display("FAIL full_first_pop: got vld=%b data=%h rdy=%b expected vld=1 data=%h rdy=1", out_valid, out_data, in_ready, w1);
        end
        tick();
        tests_run++;
        if ({out_valid, enc_count} !== {1'b0, 16'd4}) begin
            tests_failed++; $display("FAIL full_drained: got vld=%b cnt=%0d expected vld=0 cnt=4", out_valid, enc_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:11] exp;
        in_valid = 1'b1; out_ready = 1'b0; in_data = 8'hB0;
        exp = wd(8'hB0, ms); ms = nx(ms);
        tick();
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, exp}) begin
            tests_failed++; $display("FAIL b2b_prime: got vld=%b data=%h expected vld=1 data=%h", out_valid, out_data, exp);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = 8'hB0 + 8'(i);
            exp = wd(in_data, ms); ms = nx(ms);
            tick();
            tests_run++;
            if ({out_valid, out_data, in_ready} !== {1'b1, exp, 1'b1}) begin
                tests_failed++;
                $display("FAIL b2b_word%0d: got vld=%b data=%h rdy=%b expected vld=1 data=%h rdy=1",
                         i, out_valid, out_data, in_ready, exp);
            end
        end
        in_valid = 1'b0;
        tick();
        tests_run++;
        if ({out_valid, enc_count} !== {1'b0, 16'd15}) begin
            tests_failed++; $display("FAIL b2b_drain: got vld=%b cnt=%0d expected vld=0 cnt=15", out_valid, enc_count);
        end
    endtask

    task automatic test_reseed();
        in_valid = 1'b0; out_ready = 1'b1;
        seed_valid = 1'b1; seed_data = 16'h0000;
        tick();
        seed_valid = 1'b0;
        tests_run++;
        if ({out_valid, enc_count} !== {1'b0, 16'd15}) begin
            tests_failed++; $display("FAIL reseed_only: got vld=%b cnt=%0d expected vld=0 cnt=15", out_valid, enc_count);
        end
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, 12'h5A8}) begin
            tests_failed++; $display("FAIL reseed_zero_seed: got vld=%b data=%h expected vld=1 data=5a8", out_valid, out_data);
        end
        seed_valid = 1'b1; seed_data = 16'h00F0; in_data = 8'h3C;
        tick();
        seed_valid = 1'b0;
        tests_run++;
        if (out_data !== 12'h3CC) begin
            tests_failed++; $display("FAIL reseed_coincident_old_r: got data=%h expected 3cc", out_data);
        end
        tick();
        tests_run++;
        if (out_data !== 12'h3C0) begin
            tests_failed++; $display("FAIL reseed_new_seed: got data=%h expected 3c0", out_data);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
        tick();
        in_data = 8'h88;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, in_ready} !== 2'b10) begin
            tests_failed++; $display("FAIL midrst_buffered: got vld=%b rdy=%b expected vld=1 rdy=0", out_valid, in_ready);
        end
        rst = 1'b1; seed_valid = 1'b1; seed_data = 16'h1234; out_ready = 1'b1;
        tick();
        rst = 1'b0; seed_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if ({out_valid, out_data, enc_count} !== {1'b0, 12'h000, 16'h0000}) begin
            tests_failed++;
            $display("FAIL midrst_cleared: got vld=%b data=%h cnt=%h expected vld=0 data=000 cnt=0000", out_valid, out_data, enc_count);
        end
        in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests_run++;
        if ({out_valid, out_data} !== {1'b1, 12'h008}) begin
            tests_failed++; $display("FAIL midrst_seed_r: got vld=%b data=%h expected vld=1 data=008", out_valid, out_data);
        end
    endtask

    task automatic test_count_wrap();
        int cyc;
        in_valid = 1'b1; in_data = 8'h05; out_ready = 1'b1;
        cyc = 0;
        while (enc_count !== 16'hFFFF && cyc < 70000) begin
            tick();
            cyc++;
        end
        tests_run++;
        if (enc_count !== 16'hFFFF) begin
            tests_failed++; $display("FAIL wrap_reach_ffff: got cnt=%h expected ffff within budget", enc_count);
        end
        tick();
        tests_run++;
        if ({enc_count, out_valid} !== {16'h0000, 1'b1}) begin
            tests_failed++; $display("FAIL wrap_to_zero: got cnt=%h vld=%b expected cnt=0000 vld=1", enc_count, out_valid);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        ms = 16'h0000;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        seed_valid = 1'b0; seed_data = 16'h0000;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_reseed();
        test_reset_mid();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
